// File: rtl/axi_read_slave.sv
// AXI3 read-only slave in front of a registered-read word memory.
// One burst at a time; each beat is fetched, captured, then presented on R.
// Error bursts (DECERR/SLVERR) keep the same beat timing but never touch memory.
module axi_read_slave #(
  parameter int DATA_W = 32,
  parameter int MEM_AW = 7
) (
  input  logic              ACLK,
  input  logic              ARESETn,
  input  logic [3:0]        ARID,
  input  logic [31:0]       ARADDR,
  input  logic [3:0]        ARLEN,
  input  logic [2:0]        ARSIZE,
  input  logic [1:0]        ARBURST,
  input  logic [1:0]        ARLOCK,
  input  logic [3:0]        ARCACHE,
  input  logic [2:0]        ARPROT,
  input  logic              ARVALID,
  output logic              ARREADY,
  output logic [3:0]        RID,
  output logic [DATA_W-1:0] RDATA,
  output logic [1:0]        RRESP,
  output logic              RLAST,
  output logic              RVALID,
  input  logic              RREADY,
  output logic              mem_ren,
  output logic [MEM_AW-1:0] mem_raddr,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, FETCH, CAPT, SEND} state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;
  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  state_t              state_q, state_d;
  logic [3:0]          id_q, id_d;
  logic [MEM_AW-1:0]   addr_q, addr_d;
  logic [3:0]          len_q, len_d;
  logic [1:0]          burst_q, burst_d;
  logic [3:0]          beat_q, beat_d;
  logic [1:0]          resp_q, resp_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;

  logic [1:0]          ar_resp;
  logic                last_beat;
  logic [MEM_AW-1:0]   addr_inc;
  logic [MEM_AW-1:0]   wrap_mask;
  logic [MEM_AW-1:0]   addr_next;

  // Lock/cache/protection attributes and the byte offset carry no meaning here.
  logic unused_inputs;
  assign unused_inputs = ^{ARLOCK, ARCACHE, ARPROT, ARADDR[1:0]};

  // Response for the incoming request: out-of-range address beats any slave error.
  always_comb begin
    ar_resp = RESP_OKAY;
    if (ARADDR[31:MEM_AW+2] != '0) begin
      ar_resp = RESP_DECERR;
    end else if ((ARSIZE > 3'b010) || (ARBURST == 2'b11) ||
                 ((ARBURST == BURST_WRAP) && (ARLEN != 4'd1) && (ARLEN != 4'd3) &&
                  (ARLEN != 4'd7) && (ARLEN != 4'd15))) begin
      ar_resp = RESP_SLVERR;
    end
  end

  // Next word address; for WRAP the legal lengths (1,3,7,15) double as the low-bit mask.
  always_comb begin
    addr_inc  = addr_q + MEM_AW'(1);
    wrap_mask = MEM_AW'(len_q);
    addr_next = addr_inc;
    case (burst_q)
      BURST_FIXED: addr_next = addr_q;
      BURST_INCR:  addr_next = addr_inc;
      BURST_WRAP:  addr_next = (addr_q & ~wrap_mask) | (addr_inc & wrap_mask);
      default:     addr_next = addr_q;
    endcase
  end

  assign last_beat = (beat_q == len_q);

  // Burst sequencer: accept AR, then FETCH -> CAPT -> SEND per beat.
  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    addr_d  = addr_q;
    len_d   = len_q;
    burst_d = burst_q;
    beat_d  = beat_q;
    resp_d  = resp_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: begin
        if (ARVALID) begin
          id_d    = ARID;
          addr_d  = ARADDR[MEM_AW+1:2];
          len_d   = ARLEN;
          burst_d = ARBURST;
          beat_d  = '0;
          resp_d  = ar_resp;
          state_d = FETCH;
        end
      end
      FETCH: state_d = CAPT;
      CAPT: begin
        rdata_d = (resp_q == RESP_OKAY) ? mem_rdata : '0;
        state_d = SEND;
      end
      SEND: begin
        if (RREADY) begin
          if (last_beat) begin
            state_d = IDLE;
          end else begin
            beat_d  = beat_q + 4'd1;
            addr_d  = addr_next;
            state_d = FETCH;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and burst context registers.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_q <= IDLE;
      id_q    <= '0;
      addr_q  <= '0;
      len_q   <= '0;
      burst_q <= '0;
      beat_q  <= '0;
      resp_q  <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      burst_q <= burst_d;
      beat_q  <= beat_d;
      resp_q  <= resp_d;
      rdata_q <= rdata_d;
    end
  end

  // ARREADY is gated by reset so it reads 0 while held in reset, 1 right after release.
  assign ARREADY   = (state_q == IDLE) && ARESETn;
  assign RVALID    = (state_q == SEND);
  assign RLAST     = (state_q == SEND) && last_beat;
  assign RID       = id_q;
  assign RDATA     = rdata_q;
  assign RRESP     = resp_q;
  assign mem_ren   = (state_q == FETCH) && (resp_q == RESP_OKAY);
  assign mem_raddr = addr_q;

  logic unused_resp_consts;
  assign unused_resp_consts = ^{RESP_SLVERR, RESP_DECERR};

endmodule

// File: tb/tb_axi_read_slave.sv
// Directed bench for axi_read_slave with a registered-read memory model.
module tb_axi_read_slave;

  logic        ACLK = 1'b0;
  logic        ARESETn = 1'b0;
  logic [3:0]  ARID = '0;
  logic [31:0] ARADDR = '0;
  logic [3:0]  ARLEN = '0;
  logic [2:0]  ARSIZE = '0;
  logic [1:0]  ARBURST = '0;
  logic [1:0]  ARLOCK = '0;
  logic [3:0]  ARCACHE = '0;
  logic [2:0]  ARPROT = '0;
  logic        ARVALID = 1'b0;
  logic        ARREADY;
  logic [3:0]  RID;
  logic [31:0] RDATA;
  logic [1:0]  RRESP;
  logic        RLAST;
  logic        RVALID;
  logic        RREADY = 1'b1;
  logic        mem_ren;
  logic [6:0]  mem_raddr;
  logic [31:0] mem_rdata = '0;

  int total = 0;
  int bad = 0;
  logic [31:0] mem [0:127];
  int ren_log[$];
  int exp_addr[$];
  logic [31:0] exp_data[$];

  axi_read_slave #(.DATA_W(32), .MEM_AW(7)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
    .ARLOCK(ARLOCK), .ARCACHE(ARCACHE), .ARPROT(ARPROT), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY),
    .mem_ren(mem_ren), .mem_raddr(mem_raddr), .mem_rdata(mem_rdata)
  );

  always #5 ACLK = ~ACLK;

  // Registered-read memory; every read address is logged for later comparison.
  always @(posedge ACLK) begin
    if (mem_ren) begin
      mem_rdata <= mem[mem_raddr];
      ren_log.push_back(int'(mem_raddr));
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // One AR transfer plus its R beats; stop_after aborts after that many beats.
  task automatic run_burst(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                           input logic [2:0] size, input logic [1:0] burst, input logic [1:0] resp,
                           input int stall_beat, input int stall_cyc, input int stop_after);
    int n;
    int ren0;
    @(negedge ACLK);
    check("arready_idle", ARREADY, 1);
    ARID = id; ARADDR = addr; ARLEN = len; ARSIZE = size; ARBURST = burst;
    ARLOCK = 2'b01; ARCACHE = 4'hF; ARPROT = 3'h7; ARVALID = 1'b1;
    ren0 = ren_log.size();
    @(posedge ACLK);
    #1;
    ARVALID = 1'b0; ARID = '0; ARADDR = '0; ARLEN = '0;
    for (int b = 0; b <= int'(len); b++) begin
      if (b == stop_after) return;
      n = 0;
      do begin
        @(negedge ACLK);
        n++;
      end while (!RVALID && n < 10);
      check("r_latency", n, 3);
      if (!RVALID) return;
      check("rdata", RDATA, exp_data[b]);
      check("rid", RID, id);
      check("rresp", RRESP, resp);
      check("rlast", RLAST, (b == int'(len)));
      check("arready_busy", ARREADY, 0);
      if (b == stall_beat) begin
        RREADY = 1'b0;
        repeat (stall_cyc) begin
          @(negedge ACLK);
          check("hold_rvalid", RVALID, 1);
          check("hold_rdata", RDATA, exp_data[b]);
          check("hold_rlast", RLAST, (b == int'(len)));
        end
        check("hold_no_ren", ren_log.size() - ren0, (exp_addr.size() == 0) ? 0 : b + 1);
        RREADY = 1'b1;
      end
      @(posedge ACLK);
      #1;
    end
    check("ren_count", ren_log.size() - ren0, exp_addr.size());
    foreach (exp_addr[i]) begin
      if (ren0 + i < ren_log.size()) check("raddr", ren_log[ren0 + i], exp_addr[i]);
    end
    @(negedge ACLK);
    check("arready_after", ARREADY, 1);
    check("rvalid_after", RVALID, 0);
    $display("burst id=%0h addr=%0h len=%0d burst=%0b resp=%0b done", id, addr, len, burst, resp);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_arready"}, ARREADY, 0);
    check({tag, "_rvalid"}, RVALID, 0);
    check({tag, "_rlast"}, RLAST, 0);
    check({tag, "_mem_ren"}, mem_ren, 0);
    check({tag, "_rdata"}, RDATA, 0);
    check({tag, "_rid"}, RID, 0);
    check({tag, "_rresp"}, RRESP, 0);
    check({tag, "_mem_raddr"}, mem_raddr, 0);
  endtask

  initial begin
    int ren_rst;
    for (int i = 0; i < 128; i++) mem[i] = 32'h1000 + i;
    mem[5] = 32'hA5A5_0001;

    // Reset state, then release.
    repeat (2) @(negedge ACLK);
    check_reset_outputs("reset");
    ARESETn = 1'b1;
    #1;
    check("arready_release", ARREADY, 1);

    // Single beat.
    exp_addr = {5}; exp_data = {32'hA5A5_0001};
    run_burst(4'h4, 32'h14, 4'd0, 3'b010, 2'b01, 2'b00, -1, 0, 99);

    // INCR burst of four.
    mem[2] = 32'd1; mem[3] = 32'd2; mem[4] = 32'd3; mem[5] = 32'd4;
    exp_addr = {2, 3, 4, 5}; exp_data = {32'd1, 32'd2, 32'd3, 32'd4};
    run_burst(4'h1, 32'h8, 4'd3, 3'b010, 2'b01, 2'b00, -1, 0, 99);

    // WRAP of four starting mid-window.
    exp_addr = {6, 7, 4, 5}; exp_data = {32'h1006, 32'h1007, 32'd3, 32'd4};
    run_burst(4'h2, 32'h18, 4'd3, 3'b010, 2'b10, 2'b00, -1, 0, 99);

    // WRAP of two from the odd word.
    exp_addr = {7, 6}; exp_data = {32'h1007, 32'h1006};
    run_burst(4'h6, 32'h1C, 4'd1, 3'b010, 2'b10, 2'b00, -1, 0, 99);

    // Backpressure on first beat for 5 cycles.
    exp_addr = {16, 17}; exp_data = {32'h1010, 32'h1011};
    run_burst(4'h3, 32'h40, 4'd1, 3'b010, 2'b01, 2'b00, 0, 5, 99);

    // INCR wrapping past the top word.
    exp_addr = {127, 0}; exp_data = {32'h107F, 32'h1000};
    run_burst(4'h5, 32'h1FC, 4'd1, 3'b010, 2'b01, 2'b00, -1, 0, 99);

    // FIXED burst.
    exp_addr = {8, 8, 8}; exp_data = {32'h1008, 32'h1008, 32'h1008};
    run_burst(4'h7, 32'h20, 4'd2, 3'b010, 2'b00, 2'b00, -1, 0, 99);

    // DECERR: out-of-range address.
    exp_addr = {}; exp_data = {32'd0, 32'd0, 32'd0};
    run_burst(4'h8, 32'h400, 4'd2, 3'b010, 2'b01, 2'b11, -1, 0, 99);

    // SLVERR: oversize transfer, with a stall to confirm no fetch happens.
    exp_addr = {}; exp_data = {32'd0, 32'd0};
    run_burst(4'hA, 32'h10, 4'd1, 3'b101, 2'b01, 2'b10, 1, 3, 99);

    // SLVERR: reserved burst type.
    exp_addr = {}; exp_data = {32'd0};
    run_burst(4'hB, 32'h0, 4'd0, 3'b010, 2'b11, 2'b10, -1, 0, 99);

    // SLVERR: WRAP with an illegal length.
    exp_addr = {}; exp_data = {32'd0, 32'd0, 32'd0};
    run_burst(4'hC, 32'h0, 4'd2, 3'b010, 2'b10, 2'b10, -1, 0, 99);

    // Reset in the middle of an eight-beat burst, right after beat 2.
    exp_addr = {0, 1, 2, 3, 4, 5, 6, 7};
    exp_data = {32'h1000, 32'h1001, 32'd1, 32'd2, 32'd3, 32'd4, 32'h1006, 32'h1007};
    run_burst(4'h9, 32'h0, 4'd7, 3'b010, 2'b01, 2'b00, -1, 0, 2);
    ARESETn = 1'b0;
    #1;
    check_reset_outputs("midrst");
    ren_rst = ren_log.size();
    repeat (2) @(negedge ACLK);
    ARESETn = 1'b1;
    repeat (6) begin
      @(negedge ACLK);
      check("post_rst_rvalid", RVALID, 0);
      check("post_rst_arready", ARREADY, 1);
    end
    check("post_rst_no_ren", ren_log.size() - ren_rst, 0);

    // Normal operation resumes after the abort.
    exp_addr = {16}; exp_data = {32'h1010};
    run_burst(4'hD, 32'h40, 4'd0, 3'b010, 2'b01, 2'b00, -1, 0, 99);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/axi_read_slave.md
AXI_READ_SLAVE -- requirements
Module: axi_read_slave

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning RDATA and mem_rdata width.
REQ-002 SHALL have parameter MEM_AW, default 7, meaning memory word-address width.
REQ-003 SHALL have port ACLK, input, 1, the single clock; all logic is on its rising edge.
REQ-004 SHALL have port ARESETn, input, 1; reset is asynchronous and active-low.
REQ-005 SHALL have AR inputs: ARID 4, ARADDR 32, ARLEN 4, ARSIZE 3, ARBURST 2, ARLOCK 2, ARCACHE 4, ARPROT 3, ARVALID 1.
REQ-006 SHALL have port ARREADY, output, 1, address accept.
REQ-007 SHALL have R outputs: RID 4, RDATA DATA_W, RRESP 2, RLAST 1, RVALID 1.
REQ-008 SHALL have port RREADY, input, 1, master accepts beat.
REQ-009 SHALL have memory-side ports: mem_ren output 1; mem_raddr output MEM_AW (word index); mem_rdata input DATA_W.
REQ-010 SHALL treat mem_rdata as valid in the cycle after a mem_ren=1 cycle (registered-read memory).

Function
REQ-011 SHALL implement FSM states IDLE, FETCH, CAPT, SEND.
REQ-012 IDLE: ARREADY=1; on ARVALID&ARREADY capture ARID, ARADDR, ARLEN, ARSIZE, ARBURST; set beat counter to 0; go FETCH.
REQ-013 ARLOCK, ARCACHE, ARPROT SHALL be accepted and ignored.
REQ-014 ARREADY SHALL be 0 in every state except IDLE; only one outstanding burst.
REQ-015 FETCH: mem_ren=1 for exactly one cycle with mem_raddr = current word address; go CAPT.
REQ-016 CAPT: register mem_rdata into RDATA; go SEND.
REQ-017 SEND: RVALID=1; RID=captured ARID; RLAST=1 iff beat counter == captured ARLEN; RDATA, RRESP, RLAST, RID SHALL be stable while RVALID=1 and RREADY=0.
REQ-018 On RVALID&RREADY with RLAST=0: increment beat counter, advance address, go FETCH.
REQ-019 On RVALID&RREADY with RLAST=1: go IDLE; ARREADY=1 in the next cycle.
REQ-020 Latency: first RVALID SHALL rise 3 cycles after the AR-handshake edge; each next RVALID SHALL rise 3 cycles after the previous R handshake.
REQ-021 Burst length SHALL be ARLEN+1 beats (1..16); exactly that many beats SHALL be returned, including error bursts.
REQ-022 Start word address SHALL be ARADDR[MEM_AW+1:2]; ARADDR[1:0] ignored.
REQ-023 FIXED (00): word address constant for all beats.
REQ-024 INCR (01): word address +1 per beat, modulo 2^MEM_AW (wrap 127->0).
REQ-025 WRAP (10): word address +1 per beat, wrapping within an aligned window of ARLEN+1 words; lower log2(ARLEN+1) bits increment, upper bits fixed.
REQ-026 RRESP SHALL be DECERR (11) if ARADDR[31:MEM_AW+2] != 0.
REQ-027 Else RRESP SHALL be SLVERR (10) if ARSIZE > 3'b010, ARBURST == 11, or ARBURST == WRAP with ARLEN not in {1,3,7,15}.
REQ-028 Else RRESP SHALL be OKAY (00).
REQ-029 For any error burst: mem_ren SHALL stay 0, and RDATA SHALL be 0 on every beat; FETCH/CAPT timing unchanged.
REQ-030 RRESP SHALL be constant for all beats of a burst.

Reset
REQ-031 While ARESETn=0: state IDLE; ARREADY, RVALID, RLAST, mem_ren = 0; RDATA, RID, RRESP, mem_raddr, beat counter = 0.
REQ-032 First rising ACLK after deassertion SHALL see ARREADY=1.
REQ-033 Reset mid-burst SHALL abort it; no remaining beats are issued after release.

Verification
REQ-034 Single read: memory word 5 = 32'hA5A5_0001; AR ARID=4, ARADDR=0x14, ARLEN=0, INCR, ARSIZE=010, RREADY=1 -> one beat RDATA=A5A50001, RID=4, RRESP=00, RLAST=1, RVALID 3 cycles after AR.
REQ-035 INCR burst: words 2..5 = 1,2,3,4; ARADDR=0x8, ARLEN=3 -> RDATA 1,2,3,4; RLAST only on beat 4; mem_raddr 2,3,4,5.
REQ-036 WRAP burst: ARADDR=0x18 (word 6), ARLEN=3, WRAP -> mem_raddr 6,7,4,5.
REQ-037 Backpressure: ARLEN=1, RREADY=0 for 5 cycles on beat 1 -> RVALID and RDATA held stable, no mem_ren pulse; beat 2 follows 3 cycles after release.
REQ-038 Errors: ARADDR=0x400 -> 1+ARLEN beats RRESP=11, RDATA=0; ARSIZE=101 -> RRESP=10, mem_ren never asserted.
REQ-039 Reset mid-burst: ARLEN=7, assert ARESETn=0 after beat 2 -> all outputs at reset values at once; after release ARREADY=1, RVALID=0 until a new AR.
